config_frame_writer: RTL and testbench

Programming-side writer for the frame-based configuration latches in the logic and I/O tiles. It accepts a serial bitstream through a valid/ready handshake and assembles fixed-length frames of address bits followed by data bits. For each frame it drives the shared `enable`/`address`/`data_in` bus with a setup / strobe / hold sequence that the address-decoded latch memories (e.g. GPIO direction latches) capture on `enable`. It sits between the bitstream loader and the fabric's frame-decoder tree.

---
 rtl/config_frame_writer_pkg.sv | 25 ++
 rtl/config_frame_shifter.sv | 48 ++++
 rtl/config_frame_writer.sv | 170 +++++++++++++++++
 tb/tb_config_frame_writer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_frame_writer_pkg.sv
// Shared types and width helpers for the configuration frame writer.
// Widths depend on instance parameters, so they are provided as constant functions.
package config_frame_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Total bits per frame: address bits followed by data bits.
    function automatic int unsigned frame_width(input int unsigned addr_width,
                                                input int unsigned data_width);
        return addr_width + data_width;
    endfunction

    // Width of the frame_count output: must hold the value num_frames.
    function automatic int unsigned count_width(input int unsigned num_frames);
        return $clog2(num_frames + 1);
    endfunction

endpackage

// File: rtl/config_frame_shifter.sv
// Serial-in frame assembler: shift register, bit counter and frame-complete /
// truncation detection. Only FRAME_WIDTH-1 bits are stored; the last bit is bypassed.
module config_frame_shifter
    import config_frame_writer_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH = frame_width(4, 1)
) (
    input  logic                   prog_clk,
    input  logic                   prog_rst_n,
    input  logic                   clear,
    input  logic                   xfer,
    input  logic                   bs_data,
    input  logic                   bs_last,
    output logic [FRAME_WIDTH-1:0] frame_next_c,
    output logic                   frame_done_c,
    output logic                   truncate_c
);

    localparam int unsigned CNT_W = $clog2(FRAME_WIDTH + 1);

    logic [FRAME_WIDTH-2:0] partial_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic                   last_bit_c;

    assign frame_next_c = {partial_q, bs_data};
    assign last_bit_c   = (bit_cnt_q == CNT_W'(FRAME_WIDTH - 1));
    assign frame_done_c = xfer && last_bit_c;
    assign truncate_c   = xfer && bs_last && !last_bit_c;

    // Counter restarts after a full frame or a truncating bs_last, dropping any partial frame.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            partial_q <= '0;
            bit_cnt_q <= '0;
        end else if (clear) begin
            partial_q <= '0;
            bit_cnt_q <= '0;
        end else if (xfer) begin
            partial_q <= frame_next_c[FRAME_WIDTH-2:0];
            if (last_bit_c || bs_last) begin
                bit_cnt_q <= '0;
            end else begin
                bit_cnt_q <= CNT_W'(bit_cnt_q + 1'b1);
            end
        end
    end

endmodule

// File: rtl/config_frame_writer.sv
// Frame-based configuration writer: assembles serial frames and drives the
// enable/address/data_in latch bus with a setup / strobe / hold sequence.
module config_frame_writer
    import config_frame_writer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned DATA_WIDTH    = 1,
    parameter int unsigned NUM_FRAMES    = 10,
    parameter int unsigned STROBE_CYCLES = 1
) (
    input  logic                                 prog_clk,
    input  logic                                 prog_rst_n,
    input  logic                                 cfg_start,
    input  logic                                 bs_valid,
    input  logic                                 bs_data,
    input  logic                                 bs_last,
    output logic                                 bs_ready,
    output logic                                 enable,
    output logic [ADDR_WIDTH-1:0]                address,
    output logic [DATA_WIDTH-1:0]                data_in,
    output logic                                 cfg_done,
    output logic                                 cfg_err,
    output logic [count_width(NUM_FRAMES)-1:0]   frame_count
);

    localparam int unsigned FRAME_WIDTH  = frame_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int unsigned COUNT_WIDTH  = count_width(NUM_FRAMES);
    localparam int unsigned STROBE_CNT_W = $clog2(STROBE_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    state_e state_q, state_d;

    logic                    bs_ready_d;
    logic                    enable_d;
    logic [ADDR_WIDTH-1:0]   address_d;
    logic [DATA_WIDTH-1:0]   data_in_d;
    logic                    cfg_done_d;
    logic                    cfg_err_d;
    logic [COUNT_WIDTH-1:0]  frame_count_d;
    logic                    pending_done_q, pending_done_d;
    logic                    strobed_q, strobed_d;
    logic [STROBE_CNT_W-1:0] strobe_cnt_q, strobe_cnt_d;

    logic                   xfer_c;
    logic                   shift_clear_c;
    logic                   addr_illegal_c;
    logic [FRAME_WIDTH-1:0] frame_next_c;
    logic                   frame_done_c;
    logic                   truncate_c;

    // bs_ready is registered and equals (state == SHIFT), so no path from bs_valid.
    assign xfer_c         = bs_valid && bs_ready;
    assign addr_illegal_c = (32'(address) >= 32'(NUM_FRAMES));

    config_frame_shifter #(
        .FRAME_WIDTH (FRAME_WIDTH)
    ) u_shifter (
        .prog_clk     (prog_clk),
        .prog_rst_n   (prog_rst_n),
        .clear        (shift_clear_c),
        .xfer         (xfer_c),
        .bs_data      (bs_data),
        .bs_last      (bs_last),
        .frame_next_c (frame_next_c),
        .frame_done_c (frame_done_c),
        .truncate_c   (truncate_c)
    );

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next values of every registered output / status flag.
    always_comb begin
        state_d        = state_q;
        address_d      = address;
        data_in_d      = data_in;
        cfg_err_d      = cfg_err;
        frame_count_d  = frame_count;
        pending_done_d = pending_done_q;
        strobed_d      = strobed_q;
        strobe_cnt_d   = strobe_cnt_q;
        shift_clear_c  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (cfg_start) begin
                    state_d        = ST_SHIFT;
                    frame_count_d  = '0;
                    cfg_err_d      = 1'b0;
                    pending_done_d = 1'b0;
                    shift_clear_c  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (truncate_c) begin
                    cfg_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (frame_done_c) begin
                    address_d      = frame_next_c[FRAME_WIDTH-1 -: ADDR_WIDTH];
                    data_in_d      = frame_next_c[DATA_WIDTH-1:0];
                    pending_done_d = bs_last;
                    state_d        = ST_SETUP;
                end
            end
            ST_SETUP: begin
                strobe_cnt_d = '0;
                if (addr_illegal_c) begin
                    cfg_err_d = 1'b1;
                    strobed_d = 1'b0;
                    state_d   = ST_HOLD;
                end else begin
                    strobed_d = 1'b1;
                    state_d   = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (strobe_cnt_q == STROBE_CNT_W'(STROBE_CYCLES - 1)) begin
                    state_d = ST_HOLD;
                end else begin
                    strobe_cnt_d = STROBE_CNT_W'(strobe_cnt_q + 1'b1);
                end
            end
            ST_HOLD: begin
                if (strobed_q && (frame_count != COUNT_MAX)) begin
                    frame_count_d = COUNT_WIDTH'(frame_count + 1'b1);
                end
                state_d = pending_done_q ? ST_DONE : ST_SHIFT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        bs_ready_d = (state_d == ST_SHIFT);
        enable_d   = (state_d == ST_STROBE);
        cfg_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            bs_ready       <= 1'b0;
            enable         <= 1'b0;
            address        <= '0;
            data_in        <= '0;
            cfg_done       <= 1'b0;
            cfg_err        <= 1'b0;
            frame_count    <= '0;
            pending_done_q <= 1'b0;
            strobed_q      <= 1'b0;
            strobe_cnt_q   <= '0;
        end else begin
            bs_ready       <= bs_ready_d;
            enable         <= enable_d;
            address        <= address_d;
            data_in        <= data_in_d;
            cfg_done       <= cfg_done_d;
            cfg_err        <= cfg_err_d;
            frame_count    <= frame_count_d;
            pending_done_q <= pending_done_d;
            strobed_q      <= strobed_d;
            strobe_cnt_q   <= strobe_cnt_d;
        end
    end

endmodule

// File: tb/tb_config_frame_writer.sv
// Directed bench for config_frame_writer with a strobe scoreboard (STROBE_CYCLES=3).
module tb_config_frame_writer;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 1;
    localparam int unsigned NF = 10;
    localparam int unsigned SC = 3;
    localparam int unsigned CW = 4;

    logic          prog_clk;
    logic          prog_rst_n;
    logic          cfg_start;
    logic          bs_valid;
    logic          bs_data;
    logic          bs_last;
    logic          bs_ready;
    logic          enable;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in;
    logic          cfg_done;
    logic          cfg_err;
    logic [CW-1:0] frame_count;

    int total = 0;
    int bad   = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_f;
    logic             en_prev  = 1'b0;
    logic [AW-1:0]    addr_prev = '0;
    int               run_len  = 0;

    config_frame_writer #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .NUM_FRAMES    (NF),
        .STROBE_CYCLES (SC)
    ) dut (
        .prog_clk    (prog_clk),
        .prog_rst_n  (prog_rst_n),
        .cfg_start   (cfg_start),
        .bs_valid    (bs_valid),
        .bs_data     (bs_data),
        .bs_last     (bs_last),
        .bs_ready    (bs_ready),
        .enable      (enable),
        .address     (address),
        .data_in     (data_in),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .frame_count (frame_count)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // One handshake transfer, preceded by a random idle gap on bs_valid.
    task automatic send_bit(input logic b, input logic last, input int max_gap);
        int n;
        n = 0;
        repeat ($urandom_range(max_gap, 0)) tick();
        bs_valid = 1'b1;
        bs_data  = b;
        bs_last  = last;
        while (!bs_ready && n < 50) begin
            tick();
            n++;
        end
        check("bit_accept", 32'(n < 50), 1);
        tick();
        bs_valid = 1'b0;
        bs_last  = 1'b0;
        bs_data  = 1'b0;
    endtask

    task automatic send_frame(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic last, input int max_gap, input logic legal);
        logic [AW+DW-1:0] f;
        f = {a, d};
        if (legal) exp_q.push_back(f);
        for (int i = AW + DW - 1; i >= 0; i--) begin
            send_bit(f[i], last && (i == 0), max_gap);
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (!bs_ready && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!cfg_done && n < 100) begin
            tick();
            n++;
        end
    endtask

    // Strobe monitor: each rising enable consumes one expected frame write.
    always @(negedge prog_clk) begin
        if (enable && !en_prev) begin
            check("strobe_expected", 32'(exp_q.size() != 0), 1);
            check("addr_stable_at_rise", 32'(address), 32'(addr_prev));
            if (exp_q.size() != 0) begin
                mon_f = exp_q.pop_front();
                check("strobe_addr", 32'(address), 32'(mon_f[AW+DW-1:DW]));
                check("strobe_data", 32'(data_in), 32'(mon_f[DW-1:0]));
            end
            run_len = 1;
        end else if (enable) begin
            run_len++;
            check("addr_during_strobe", 32'(address), 32'(addr_prev));
        end else if (en_prev && prog_rst_n) begin
            check("strobe_len", run_len, SC);
        end
        en_prev   = enable;
        addr_prev = address;
    end

    initial begin
        int n;
        prog_rst_n = 1'b0;
        cfg_start  = 1'b0;
        bs_valid   = 1'b0;
        bs_data    = 1'b0;
        bs_last    = 1'b0;
        repeat (3) @(posedge prog_clk);
        #1;
        check("rst_ready", 32'(bs_ready), 0);
        check("rst_enable", 32'(enable), 0);
        check("rst_address", 32'(address), 0);
        check("rst_data", 32'(data_in), 0);
        check("rst_done", 32'(cfg_done), 0);
        check("rst_err", 32'(cfg_err), 0);
        check("rst_count", 32'(frame_count), 0);
        prog_rst_n = 1'b1;
        tick();
        bs_valid = 1'b1;
        tick();
        tick();
        check("idle_ready", 32'(bs_ready), 0);
        bs_valid = 1'b0;

        // Single legal frame: address 3, data 1
        pulse_start();
        check("arm_ready", 32'(bs_ready), 1);
        check("arm_done", 32'(cfg_done), 0);
        send_frame(4'h3, 1'b1, 1'b1, 0, 1'b1);
        check("setup_addr", 32'(address), 32'h3);
        check("setup_data", 32'(data_in), 1);
        check("setup_enable", 32'(enable), 0);
        wait_done(n);
        check("done_latency", n, SC + 2);
        check("single_count", 32'(frame_count), 1);
        check("single_err", 32'(cfg_err), 0);
        check("done_addr_kept", 32'(address), 32'h3);

        // Re-arm, then illegal address followed by a legal frame
        pulse_start();
        check("rearm_done", 32'(cfg_done), 0);
        check("rearm_count", 32'(frame_count), 0);
        check("rearm_ready", 32'(bs_ready), 1);
        send_frame(4'hC, 1'b1, 1'b0, 0, 1'b0);
        check("illegal_setup_addr", 32'(address), 32'hC);
        count_busy(n);
        check("illegal_busy", n, 2);
        check("illegal_err", 32'(cfg_err), 1);
        check("illegal_count", 32'(frame_count), 0);
        send_frame(4'h5, 1'b0, 1'b1, 1, 1'b1);
        wait_done(n);
        check("after_illegal_done", 32'(n < 100), 1);
        check("after_illegal_count", 32'(frame_count), 1);
        check("err_sticky", 32'(cfg_err), 1);

        // Truncated stream: bs_last on the third bit
        pulse_start();
        check("rearm_err_clear", 32'(cfg_err), 0);
        check("rearm_count2", 32'(frame_count), 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b0, 1'b0, 0);
        send_bit(1'b1, 1'b1, 0);
        check("trunc_done", 32'(cfg_done), 1);
        check("trunc_err", 32'(cfg_err), 1);
        check("trunc_count", 32'(frame_count), 0);
        check("trunc_ready", 32'(bs_ready), 0);

        // Back-pressure: ten frames with random valid gaps
        pulse_start();
        for (int a = 0; a < 10; a++) begin
            send_frame(AW'(a), DW'(a % 2), 1'(a == 9), 3, 1'b1);
            if (a != 9) begin
                count_busy(n);
                check("busy_len", n, SC + 2);
            end
        end
        wait_done(n);
        check("bp_done_latency", n, SC + 2);
        check("bp_count", 32'(frame_count), 10);
        check("bp_err", 32'(cfg_err), 0);

        // Saturation: 17 legal frames saturate a 4-bit count at 15
        pulse_start();
        for (int i = 0; i < 17; i++) begin
            send_frame(AW'(i % 10), DW'(i % 3 == 0), 1'(i == 16), 0, 1'b1);
        end
        wait_done(n);
        check("sat_count", 32'(frame_count), 15);

        // Reset while enable is high
        pulse_start();
        send_frame(4'h7, 1'b1, 1'b0, 0, 1'b1);
        n = 0;
        while (!enable && n < 20) begin
            @(negedge prog_clk);
            n++;
        end
        check("strobe_seen", 32'(enable), 1);
        #1;
        prog_rst_n = 1'b0;
        #1;
        check("arst_enable", 32'(enable), 0);
        check("arst_address", 32'(address), 0);
        check("arst_data", 32'(data_in), 0);
        check("arst_count", 32'(frame_count), 0);
        check("arst_done", 32'(cfg_done), 0);
        check("arst_err", 32'(cfg_err), 0);
        check("arst_ready", 32'(bs_ready), 0);
        repeat (2) tick();
        prog_rst_n = 1'b1;
        bs_valid = 1'b1;
        repeat (3) tick();
        check("post_rst_ready", 32'(bs_ready), 0);
        check("post_rst_enable", 32'(enable), 0);
        bs_valid = 1'b0;
        pulse_start();
        check("post_rst_arm_ready", 32'(bs_ready), 1);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
